// File: rtl/apb_req_arbiter_pkg.sv
// Shared types and widths for the APB requester arbiter.
//   STRB_W     : APB byte-strobe width
//   DATA_W     : APB data width
//   state_e    : sequencer state (IDLE, SETUP, ACCESS, RESP)
//   apb_resp_t : completion payload returned to the granted requester
package apb_req_arbiter_pkg;

  localparam int unsigned STRB_W = 4;
  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  typedef struct packed {
    logic [DATA_W-1:0] rdata;
    logic              err;
  } apb_resp_t;

endpackage

// File: rtl/apb_req_arbiter_rr_pick.sv
// Combinational round-robin picker.
//   req   : request vector, one bit per requester
//   ptr   : index of the most recently granted requester
//   gnt_c : one-hot winner, first set bit searching upward from ptr+1 (wrapping)
//   idx_c : binary index of the winner (0 when no request)
module rr_pick #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt_c,
  output logic [IDX_W-1:0]   idx_c
);

  logic [IDX_W-1:0] cand;

  // Walk from the farthest candidate to the nearest so the nearest set bit wins.
  always_comb begin
    gnt_c = '0;
    idx_c = '0;
    cand  = '0;
    for (int unsigned k = NUM_REQ; k >= 1; k--) begin
      cand = IDX_W'((32'(ptr) + k) % NUM_REQ);
      if (req[cand]) begin
        gnt_c       = '0;
        gnt_c[cand] = 1'b1;
        idx_c       = cand;
      end
    end
  end

endmodule

// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter that shares one APB completer between NUM_REQ requesters
// and sequences the SETUP/ACCESS phases for the granted one.
// Optional ACCESS-phase timeout: define APB_REQ_ARBITER_TIMEOUT_EN.
// Ports:
//   pclk, presetn               : clock, synchronous active-low reset
//   req_valid/write/addr/wdata/strb : per-requester request (flattened slices)
//   resp_valid/rdata/err        : one-hot completion pulse with read data / error
//   grant                       : one-hot owner of the current transfer
//   psel..pwdata                : APB requester outputs
//   prdata, pready, pslverr     : APB completer inputs
module apb_req_arbiter
  import apb_req_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 2,
  parameter int unsigned ADDR_W         = 8,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                      pclk,
  input  logic                      presetn,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  input  logic [NUM_REQ*STRB_W-1:0] req_strb,
  output logic [NUM_REQ-1:0]        resp_valid,
  output logic [DATA_W-1:0]         resp_rdata,
  output logic                      resp_err,
  output logic [NUM_REQ-1:0]        grant,
  output logic                      psel,
  output logic                      penable,
  output logic [ADDR_W-1:0]         paddr,
  output logic                      pwrite,
  output logic [STRB_W-1:0]         pstrb,
  output logic [DATA_W-1:0]         pwdata,
  input  logic [DATA_W-1:0]         prdata,
  input  logic                      pready,
  input  logic                      pslverr
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic [NUM_REQ-1:0]  resp_valid_q, resp_valid_d;
  logic                psel_q, psel_d;
  logic                penable_q, penable_d;
  logic                pwrite_q, pwrite_d;
  logic [ADDR_W-1:0]   paddr_q, paddr_d;
  logic [STRB_W-1:0]   pstrb_q, pstrb_d;
  logic [DATA_W-1:0]   pwdata_q, pwdata_d;
  apb_resp_t           resp_q, resp_d;

  logic [NUM_REQ-1:0]  pick_gnt_c;
  logic [IDX_W-1:0]    pick_idx_c;
  logic                sel_write_c;
  logic [ADDR_W-1:0]   sel_addr_c;
  logic [DATA_W-1:0]   sel_wdata_c;
  logic [STRB_W-1:0]   sel_strb_c;
  logic                timeout_c;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req   (req_valid),
    .ptr   (ptr_q),
    .gnt_c (pick_gnt_c),
    .idx_c (pick_idx_c)
  );

  // Route the winning requester's fields to the APB latch inputs.
  always_comb begin
    sel_write_c = 1'b0;
    sel_addr_c  = '0;
    sel_wdata_c = '0;
    sel_strb_c  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (pick_gnt_c[i]) begin
        sel_write_c = req_write[i];
        sel_addr_c  = req_addr[i*ADDR_W +: ADDR_W];
        sel_wdata_c = req_wdata[i*DATA_W +: DATA_W];
        sel_strb_c  = req_strb[i*STRB_W +: STRB_W];
      end
    end
  end

`ifdef APB_REQ_ARBITER_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] to_cnt_q, to_cnt_d;

  // Counts wait-state ACCESS cycles; cleared while in SETUP, i.e. on ACCESS entry.
  always_comb begin
    to_cnt_d  = to_cnt_q;
    timeout_c = 1'b0;
    if (state_q == ST_SETUP) begin
      to_cnt_d = '0;
    end else if ((state_q == ST_ACCESS) && !pready) begin
      to_cnt_d  = to_cnt_q + TO_W'(1);
      timeout_c = (to_cnt_d == TO_W'(TIMEOUT_CYCLES));
    end
  end

  always_ff @(posedge pclk) begin
    if (!presetn) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end
`else
  assign timeout_c = 1'b0;

  // TIMEOUT_CYCLES only matters when the timeout is built in.
  if (TIMEOUT_CYCLES == 0) begin : g_timeout_unused
  end
`endif

  // Sequencer next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    grant_d      = grant_q;
    resp_valid_d = '0;
    psel_d       = psel_q;
    penable_d    = penable_q;
    pwrite_d     = pwrite_q;
    paddr_d      = paddr_q;
    pstrb_d      = pstrb_q;
    pwdata_d     = pwdata_q;
    resp_d       = resp_q;
    case (state_q)
      ST_IDLE: begin
        if (|req_valid) begin
          state_d   = ST_SETUP;
          ptr_d     = pick_idx_c;
          grant_d   = pick_gnt_c;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          pwrite_d  = sel_write_c;
          paddr_d   = sel_addr_c;
          pwdata_d  = sel_wdata_c;
          pstrb_d   = sel_write_c ? sel_strb_c : '0;
        end
      end
      ST_SETUP: begin
        penable_d = 1'b1;
        state_d   = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (pready || timeout_c) begin
          psel_d       = 1'b0;
          penable_d    = 1'b0;
          resp_valid_d = grant_q;
          state_d      = ST_RESP;
          if (pready) begin
            resp_d.rdata = pwrite_q ? '0 : prdata;
            resp_d.err   = pslverr;
          end else begin
            resp_d.rdata = '0;
            resp_d.err   = 1'b1;
          end
        end
      end
      ST_RESP: begin
        grant_d = '0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Pointer resets to the last index so requester 0 is searched first.
  always_ff @(posedge pclk) begin
    if (!presetn) begin
      state_q      <= ST_IDLE;
      ptr_q        <= IDX_W'(NUM_REQ - 1);
      grant_q      <= '0;
      resp_valid_q <= '0;
      psel_q       <= 1'b0;
      penable_q    <= 1'b0;
      pwrite_q     <= 1'b0;
      paddr_q      <= '0;
      pstrb_q      <= '0;
      pwdata_q     <= '0;
      resp_q       <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      grant_q      <= grant_d;
      resp_valid_q <= resp_valid_d;
      psel_q       <= psel_d;
      penable_q    <= penable_d;
      pwrite_q     <= pwrite_d;
      paddr_q      <= paddr_d;
      pstrb_q      <= pstrb_d;
      pwdata_q     <= pwdata_d;
      resp_q       <= resp_d;
    end
  end

  assign grant      = grant_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_q.rdata;
  assign resp_err   = resp_q.err;
  assign psel       = psel_q;
  assign penable    = penable_q;
  assign pwrite     = pwrite_q;
  assign paddr      = paddr_q;
  assign pstrb      = pstrb_q;
  assign pwdata     = pwdata_q;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Bench for apb_req_arbiter: randomized requesters and a scheduled APB completer.
// A transaction-level model predicts each grant and completion by edge number;
// a monitor pops those predictions whenever the DUT presents SETUP or resp_valid.
module tb_apb_req_arbiter;
  import apb_req_arbiter_pkg::*;

  localparam int unsigned N  = 3;
  localparam int unsigned AW = 8;

  logic                pclk = 1'b0;
  logic                presetn;
  logic [N-1:0]        req_valid, req_write;
  logic [N*AW-1:0]     req_addr;
  logic [N*32-1:0]     req_wdata;
  logic [N*4-1:0]      req_strb;
  logic [N-1:0]        resp_valid, grant;
  logic [31:0]         resp_rdata, pwdata, prdata;
  logic                resp_err, psel, penable, pwrite, pready, pslverr;
  logic [AW-1:0]       paddr;
  logic [3:0]          pstrb;

  logic [AW-1:0]       b_addr [N];
  logic [31:0]         b_wdata[N];
  logic [3:0]          b_strb [N];

  for (genvar g = 0; g < N; g++) begin : g_flat
    assign req_addr[g*AW +: AW]  = b_addr[g];
    assign req_wdata[g*32 +: 32] = b_wdata[g];
    assign req_strb[g*4 +: 4]    = b_strb[g];
  end

  apb_req_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .TIMEOUT_CYCLES(16)) dut (
    .pclk(pclk), .presetn(presetn),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_strb(req_strb),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .grant(grant), .psel(psel), .penable(penable), .paddr(paddr),
    .pwrite(pwrite), .pstrb(pstrb), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  always #5 pclk = ~pclk;

  int cyc = 0;
  always @(posedge pclk) cyc <= cyc + 1;

  typedef struct {
    int          e;
    int          idx;
    logic        wr;
    logic [AW-1:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
  } gexp_t;

  typedef struct {
    int          e;
    int          idx;
    logic [31:0] rdata;
    logic        err;
  } rexp_t;

  gexp_t gq[$];
  rexp_t rq[$];
  gexp_t cur;
  rexp_t rcur;

  bit          rdy_at[int];
  logic [31:0] rd_at[int];
  bit          err_at[int];

  int  checks = 0;
  int  errors = 0;
  bit  mon_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compares DUT activity against the predicted transaction queues.
  always @(negedge pclk) begin
    if (mon_en) begin
      if (gq.size() > 0 && gq[0].e < cyc) begin
        chk("grant_late", 64'(cyc), 64'(gq[0].e));
        void'(gq.pop_front());
      end
      if (rq.size() > 0 && rq[0].e < cyc) begin
        chk("resp_late", 64'(cyc), 64'(rq[0].e));
        void'(rq.pop_front());
      end
      if (psel && !penable) begin
        if (gq.size() > 0) cur = gq.pop_front();
        else cur.e = -1;
        chk("setup_edge", 64'(cyc), 64'(cur.e));
        chk("setup_grant", 64'(grant), 64'(N'(1) << cur.idx));
        chk("setup_fields", 64'({paddr, pwrite, pstrb, pwdata}),
            64'({cur.addr, cur.wr, cur.strb, cur.wdata}));
      end
      if (psel && penable) begin
        chk("access_hold", 64'({grant, paddr, pwrite, pstrb, pwdata}),
            64'({N'(1) << cur.idx, cur.addr, cur.wr, cur.strb, cur.wdata}));
      end
      if (resp_valid != '0) begin
        if (rq.size() > 0) rcur = rq.pop_front();
        else rcur.e = -1;
        chk("resp_edge", 64'(cyc), 64'(rcur.e));
        chk("resp_onehot", 64'({resp_valid, grant}), 64'({N'(1) << rcur.idx, N'(1) << rcur.idx}));
        chk("resp_data", 64'({resp_rdata, resp_err}), 64'({rcur.rdata, rcur.err}));
        chk("resp_bus_idle", 64'({psel, penable}), 64'(0));
      end
      if (!psel && resp_valid == '0) chk("idle_grant", 64'(grant), 64'(0));
    end
  end

  int  ptr, free_edge, win, w;
  bit  in_flight[N];
  int  rel_e[N];
  bit  issue_en;
  bit  bad;

  // One model/stimulus step, run just after edge m.
  task automatic step(input int m);
    gexp_t g;
    rexp_t r;
    // Arbitrate on the request vector the DUT just sampled.
    if (m >= free_edge && req_valid != '0) begin
      win = -1;
      for (int k = 1; k <= N; k++)
        if (win < 0 && req_valid[(ptr + k) % N]) win = (ptr + k) % N;
      ptr = win;
      w   = $urandom_range(0, 3);
      g.e = m; g.idx = win; g.wr = req_write[win]; g.addr = b_addr[win];
      g.wdata = b_wdata[win]; g.strb = req_write[win] ? b_strb[win] : 4'h0;
      gq.push_back(g);
      r.e = m + 2 + w; r.idx = win; r.err = ($urandom_range(0, 3) == 0);
      rd_at[r.e] = $urandom; err_at[r.e] = r.err; rdy_at[r.e] = 1'b1;
      r.rdata = req_write[win] ? 32'h0 : rd_at[r.e];
      rq.push_back(r);
      if ($urandom_range(0, 1) == 1) begin
        rdy_at[m + 1] = 1'b1; rd_at[m + 1] = $urandom; err_at[m + 1] = 1'b1;
      end
      free_edge     = m + 4 + w;
      rel_e[win]    = m + 2 + w;
      in_flight[win] = 1'b1;
    end
    for (int i = 0; i < N; i++) begin
      if (in_flight[i]) begin
        if (rel_e[i] == m) begin
          in_flight[i] = 1'b0;
          req_valid[i] = 1'b0;
        end else begin
          // Granted requests may withdraw or scribble their fields freely.
          if ($urandom_range(0, 7) == 0) req_valid[i] = 1'b0;
          b_addr[i] = AW'($urandom); b_wdata[i] = $urandom; b_strb[i] = 4'($urandom);
          req_write[i] = 1'($urandom_range(0, 1));
        end
      end else if (!req_valid[i] && issue_en && $urandom_range(0, 2) == 0) begin
        req_valid[i] = 1'b1;
        req_write[i] = 1'($urandom_range(0, 1));
        b_addr[i]    = AW'($urandom);
        b_wdata[i]   = $urandom;
        b_strb[i]    = 4'($urandom);
      end
    end
    if (rdy_at.exists(m + 1)) begin
      pready = 1'b1; prdata = rd_at[m + 1]; pslverr = err_at[m + 1];
      rdy_at.delete(m + 1);
    end else begin
      pready = 1'b0; prdata = $urandom; pslverr = 1'($urandom_range(0, 1));
    end
  endtask

  initial begin
    presetn = 1'b0; req_valid = '0; req_write = '0;
    pready = 1'b0; prdata = '0; pslverr = 1'b0;
    for (int i = 0; i < N; i++) begin
      b_addr[i] = '0; b_wdata[i] = '0; b_strb[i] = '0; in_flight[i] = 1'b0; rel_e[i] = -1;
    end
    repeat (3) @(posedge pclk);
    #1;
    chk("reset_apb", 64'({psel, penable, paddr, pwrite, pstrb}), 64'(0));
    chk("reset_pwdata", 64'(pwdata), 64'(0));
    chk("reset_resp", 64'({resp_valid, resp_rdata, resp_err, grant}), 64'(0));
    presetn = 1'b1;

    // Randomized traffic, then drain.
    ptr = N - 1; free_edge = 0; issue_en = 1'b1; mon_en = 1'b1;
    for (int t = 0; t < 700; t++) begin
      @(posedge pclk); #1;
      if (t == 620) issue_en = 1'b0;
      step(cyc);
    end
    @(negedge pclk);
    mon_en = 1'b0;
    chk("grants_drained", 64'(gq.size()), 64'(0));
    chk("resps_drained", 64'(rq.size()), 64'(0));
    req_valid = '0; pready = 1'b0; pslverr = 1'b0;

    // Reset in the middle of ACCESS aborts silently and restores priority to 0.
    @(posedge pclk); #1;
    req_write[1] = 1'b0; b_addr[1] = 8'h20; req_valid = 3'b010;
    @(posedge pclk); #1;
    chk("mid_rst_grant", 64'({grant, psel}), 64'({3'b010, 1'b1}));
    repeat (3) begin @(posedge pclk); #1; end
    chk("mid_rst_access", 64'({psel, penable, resp_valid}), 64'({2'b11, 3'b000}));
    presetn = 1'b0; req_valid = 3'b111;
    @(posedge pclk); #1;
    chk("mid_rst_abort", 64'({psel, penable, grant, resp_valid}), 64'(0));
    presetn = 1'b1;
    @(posedge pclk); #1;
    chk("mid_rst_regrant", 64'({grant, resp_valid}), 64'({3'b001, 3'b000}));
    presetn = 1'b0; req_valid = '0;
    @(posedge pclk); #1;
    presetn = 1'b1;

    // Completer that never answers.
    @(posedge pclk); #1;
    req_write[1] = 1'b0; b_addr[1] = 8'h44; req_valid = 3'b010;
    @(posedge pclk); #1;
    chk("stall_grant", 64'(grant), 64'(3'b010));
`ifdef APB_REQ_ARBITER_TIMEOUT_EN
    bad = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      @(posedge pclk); #1;
      if ({psel, penable, resp_valid} !== {2'b11, 3'b000}) bad = 1'b1;
    end
    chk("timeout_wait", 64'(bad), 64'(0));
    @(posedge pclk); #1;
    chk("timeout_resp", 64'({resp_valid, resp_err, resp_rdata}), 64'({3'b010, 1'b1, 32'h0}));
    chk("timeout_bus", 64'({psel, penable}), 64'(0));
`else
    bad = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      @(posedge pclk); #1;
      if ({psel, penable, resp_valid} !== {2'b11, 3'b000}) bad = 1'b1;
    end
    chk("no_timeout_hold", 64'(bad), 64'(0));
`endif
    presetn = 1'b0; req_valid = '0;
    @(posedge pclk); #1;
    presetn = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
